// File: rtl/bm_axil_regbank.sv
// bm_axil_regbank: AXI4-Lite register bank between the PS
// interconnect and a BondMachine core (R/W outputs, RO inputs).
module bm_axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int N_IN = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                  S_AXI_ARPROT,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [N_OUT*DATA_WIDTH-1:0] bm_out,
  input  logic [N_IN*DATA_WIDTH-1:0]  bm_in,
  output logic                        irq
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = ADDR_WIDTH - LSB;
  localparam logic [IW-1:0] IDX_IN = IW'(N_OUT);
  localparam logic [IW-1:0] IDX_ST = IW'(N_OUT + N_IN);
  localparam logic [IW-1:0] IDX_EN = IW'(N_OUT + N_IN + 1);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP
  } wr_st_t;
  typedef enum logic {R_IDLE, R_RESP} rd_st_t;

  wr_st_t w_st, w_nx;
  rd_st_t r_st, r_nx;

  logic                   live;
  logic [IW-1:0]          aw_idx_q;
  logic [DATA_WIDTH-1:0]  w_data_q;
  logic [NB-1:0]          w_strb_q;
  logic [DATA_WIDTH-1:0]  out_q [N_OUT];
  logic [N_IN*DATA_WIDTH-1:0] snap_q;
  logic                   changed_q;
  logic                   irq_en_q;
  logic                   irq_q;
  logic [1:0]             bresp_q;
  logic [1:0]             rresp_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic                   aw_hs, w_hs, ar_hs;
  logic                   commit, wr_out, wr_ok, clr;
  logic [IW-1:0]          wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]  wr_data, wr_mask, rd_data;
  logic [NB-1:0]          wr_strb;
  logic                   rd_err;
  logic                   unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[LSB-1:0],
                       S_AXI_ARADDR[LSB-1:0]};

  // readies stay low until the first edge after reset release
  assign S_AXI_AWREADY = live &
    (w_st == W_IDLE || w_st == W_HAVE_W);
  assign S_AXI_WREADY = live &
    (w_st == W_IDLE || w_st == W_HAVE_AW);
  assign S_AXI_ARREADY = live & (r_st == R_IDLE);
  assign S_AXI_BVALID = (w_st == W_RESP);
  assign S_AXI_RVALID = (r_st == R_RESP);
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign irq = irq_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  assign wr_idx = aw_hs ? S_AXI_AWADDR[ADDR_WIDTH-1:LSB]
                        : aw_idx_q;
  assign wr_data = w_hs ? S_AXI_WDATA : w_data_q;
  assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb_q;
  assign rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign bm_out[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
  end

  always_comb begin
    w_nx = w_st;
    unique case (w_st)
      W_IDLE: begin
        if (aw_hs && w_hs) w_nx = W_RESP;
        else if (aw_hs) w_nx = W_HAVE_AW;
        else if (w_hs) w_nx = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs) w_nx = W_RESP;
      W_HAVE_W: if (aw_hs) w_nx = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_nx = W_IDLE;
    endcase
  end

  assign commit = (w_st != W_RESP) && (w_nx == W_RESP);

  always_comb begin
    r_nx = r_st;
    unique case (r_st)
      R_IDLE: if (ar_hs) r_nx = R_RESP;
      R_RESP: if (S_AXI_RREADY) r_nx = R_IDLE;
    endcase
  end

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NB; b++)
      wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  always_comb begin
    wr_out = 1'b0;
    wr_ok = 1'b0;
    unique case (1'b1)
      (wr_idx < IDX_IN): begin
        wr_out = 1'b1;
        wr_ok = 1'b1;
      end
      (wr_idx == IDX_ST),
      (wr_idx == IDX_EN): wr_ok = 1'b1;
      default: wr_ok = 1'b0;
    endcase
  end

  assign clr = commit && (wr_idx == IDX_ST) &&
               wr_strb[0] && wr_data[0];

  always_comb begin
    rd_data = '0;
    rd_err = 1'b0;
    unique case (1'b1)
      (rd_idx < IDX_IN): begin
        for (int k = 0; k < N_OUT; k++)
          if (rd_idx == IW'(k)) rd_data = out_q[k];
      end
      (rd_idx >= IDX_IN && rd_idx < IDX_ST): begin
        for (int j = 0; j < N_IN; j++)
          if (rd_idx == IW'(N_OUT + j))
            rd_data = snap_q[j*DATA_WIDTH +: DATA_WIDTH];
      end
      (rd_idx == IDX_ST):
        rd_data = {{(DATA_WIDTH-1){1'b0}}, changed_q};
      (rd_idx == IDX_EN):
        rd_data = {{(DATA_WIDTH-1){1'b0}}, irq_en_q};
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_st <= W_IDLE;
      r_st <= R_IDLE;
      live <= 1'b0;
    end else begin
      w_st <= w_nx;
      r_st <= r_nx;
      live <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q <= OKAY;
      rresp_q <= OKAY;
      rdata_q <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) bresp_q <= wr_ok ? OKAY : SLVERR;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? SLVERR : OKAY;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= RESET_VALUE;
      snap_q <= '0;
      changed_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++)
        if (commit && wr_out && wr_idx == IW'(k))
          out_q[k] <= (out_q[k] & ~wr_mask) |
                      (wr_data & wr_mask);
      snap_q <= bm_in;
      // a fresh input change beats a same-cycle clear
      if (bm_in != snap_q) changed_q <= 1'b1;
      else if (clr) changed_q <= 1'b0;
      if (commit && wr_idx == IDX_EN && wr_strb[0])
        irq_en_q <= wr_data[0];
      irq_q <= changed_q & irq_en_q;
    end
  end

endmodule

// File: tb/tb_bm_axil_regbank.sv
// tb_bm_axil_regbank: directed scoreboard bench for the
// BondMachine AXI4-Lite register bank (32-bit and 64-bit).
module tb_bm_axil_regbank;
  localparam logic [31:0] RV = 32'hA5A5_0000;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] bq[$];
  logic [65:0] rq[$];

  logic [2:0] prot;
  logic [7:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready;
  logic bvalid, bready, arvalid, arready;
  logic rvalid, rready, irq;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [127:0] bm_out, bm_in;

  logic [7:0] awaddr6, araddr6;
  logic awvalid6, awready6, wvalid6, wready6;
  logic bvalid6, bready6, arvalid6, arready6;
  logic rvalid6, rready6, irq6;
  logic [63:0] wdata6, rdata6;
  logic [7:0] wstrb6;
  logic [1:0] bresp6, rresp6;
  logic [127:0] bm_out6;
  logic [191:0] bm_in6;

  bm_axil_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .N_OUT(4), .N_IN(4),
    .RESET_VALUE(RV)
  ) u_dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .bm_out(bm_out), .bm_in(bm_in), .irq(irq)
  );

  bm_axil_regbank #(
    .DATA_WIDTH(64), .ADDR_WIDTH(8), .N_OUT(2), .N_IN(3),
    .RESET_VALUE(64'h0)
  ) u_dut64 (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr6), .S_AXI_AWPROT(prot),
    .S_AXI_AWVALID(awvalid6), .S_AXI_AWREADY(awready6),
    .S_AXI_WDATA(wdata6), .S_AXI_WSTRB(wstrb6),
    .S_AXI_WVALID(wvalid6), .S_AXI_WREADY(wready6),
    .S_AXI_BRESP(bresp6), .S_AXI_BVALID(bvalid6),
    .S_AXI_BREADY(bready6),
    .S_AXI_ARADDR(araddr6), .S_AXI_ARPROT(prot),
    .S_AXI_ARVALID(arvalid6), .S_AXI_ARREADY(arready6),
    .S_AXI_RDATA(rdata6), .S_AXI_RRESP(rresp6),
    .S_AXI_RVALID(rvalid6), .S_AXI_RREADY(rready6),
    .bm_out(bm_out6), .bm_in(bm_in6), .irq(irq6)
  );

  task automatic check(input string tag,
                       input logic [191:0] obs,
                       input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_b(input string tag, input logic [1:0] r);
    int n;
    logic [1:0] e;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = bq.pop_front();
    check({tag, " bvalid"}, 192'(bvalid), 192'(1));
    check({tag, " bresp"}, 192'(bresp), 192'(e));
    @(negedge clk);
  endtask

  task automatic wr32(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] r);
    int n;
    logic ha, hw;
    bq.push_back(r);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(negedge clk);
      n++;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b($sformatf("wr32 %0h", a), r);
  endtask

  task automatic rd32(input logic [7:0] a, input logic [1:0] r,
                      input logic [31:0] d);
    int n;
    logic ha;
    logic [65:0] e;
    rq.push_back({r, 32'h0, d});
    araddr = a; arvalid = 1'b1; n = 0;
    while (arvalid && n < 20) begin
      ha = arready;
      @(negedge clk);
      n++;
      if (ha) arvalid = 1'b0;
    end
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = rq.pop_front();
    check($sformatf("rd32 %0h rvalid", a), 192'(rvalid), 192'(1));
    check($sformatf("rd32 %0h", a),
          192'({rresp, 32'h0, rdata}), 192'(e));
    @(negedge clk);
  endtask

  task automatic wr64(input logic [7:0] a, input logic [63:0] d,
                      input logic [1:0] r);
    int n;
    logic ha, hw;
    logic [1:0] e;
    bq.push_back(r);
    awaddr6 = a; wdata6 = d; wstrb6 = 8'hFF;
    awvalid6 = 1'b1; wvalid6 = 1'b1; n = 0;
    while ((awvalid6 || wvalid6) && n < 20) begin
      ha = awvalid6 && awready6;
      hw = wvalid6 && wready6;
      @(negedge clk);
      n++;
      if (ha) awvalid6 = 1'b0;
      if (hw) wvalid6 = 1'b0;
    end
    awvalid6 = 1'b0; wvalid6 = 1'b0; n = 0;
    while (!bvalid6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = bq.pop_front();
    check("wr64 bvalid", 192'(bvalid6), 192'(1));
    check("wr64 bresp", 192'(bresp6), 192'(e));
    @(negedge clk);
  endtask

  task automatic rd64(input logic [7:0] a, input logic [1:0] r,
                      input logic [63:0] d);
    int n;
    logic ha;
    logic [65:0] e;
    rq.push_back({r, d});
    araddr6 = a; arvalid6 = 1'b1; n = 0;
    while (arvalid6 && n < 20) begin
      ha = arready6;
      @(negedge clk);
      n++;
      if (ha) arvalid6 = 1'b0;
    end
    arvalid6 = 1'b0; n = 0;
    while (!rvalid6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = rq.pop_front();
    check($sformatf("rd64 %0h rvalid", a), 192'(rvalid6), 192'(1));
    check($sformatf("rd64 %0h", a),
          192'({rresp6, rdata6}), 192'(e));
    @(negedge clk);
  endtask

  initial begin
    prot = 3'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1; rready = 1; bm_in = '0;
    awaddr6 = '0; araddr6 = '0; wdata6 = '0; wstrb6 = '0;
    awvalid6 = 0; wvalid6 = 0; arvalid6 = 0;
    bready6 = 1; rready6 = 1; bm_in6 = '0;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst awready", 192'(awready), 192'(0));
    check("rst wready", 192'(wready), 192'(0));
    check("rst arready", 192'(arready), 192'(0));
    check("rst bvalid", 192'(bvalid), 192'(0));
    check("rst rvalid", 192'(rvalid), 192'(0));
    check("rst resp", 192'({bresp, rresp}), 192'(0));
    check("rst rdata", 192'(rdata), 192'(0));
    check("rst bm_out", 192'(bm_out), 192'({4{RV}}));
    check("rst irq", 192'(irq), 192'(0));
    rst = 1'b0;
    #1;
    check("rel awready pre-edge", 192'(awready), 192'(0));
    @(negedge clk);
    check("rel awready", 192'(awready), 192'(1));
    check("rel wready", 192'(wready), 192'(1));
    check("rel arready", 192'(arready), 192'(1));

    for (int i = 0; i < 4; i++)
      wr32(8'(i * 4), 32'(i + 1), 4'hF, OKAY);
    for (int i = 0; i < 4; i++)
      rd32(8'(i * 4), OKAY, 32'(i + 1));
    check("bm_out seq", 192'(bm_out),
          192'(128'h00000004_00000003_00000002_00000001));

    wr32(8'h00, 32'h11223344, 4'hF, OKAY);
    wr32(8'h00, 32'hAABBCCDD, 4'b0101, OKAY);
    rd32(8'h00, OKAY, 32'h11BB33DD);
    wr32(8'h00, 32'hFFFFFFFF, 4'b0000, OKAY);
    rd32(8'h00, OKAY, 32'h11BB33DD);

    // W leads AW by three cycles
    bq.push_back(OKAY);
    awaddr = 8'h04; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    check("split wready", 192'(wready), 192'(1));
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("split wready full", 192'(wready), 192'(0));
    check("split no bvalid", 192'(bvalid), 192'(0));
    check("split awready", 192'(awready), 192'(1));
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("split bvalid +1", 192'(bvalid), 192'(1));
    check("split bresp", 192'(bresp), 192'(bq.pop_front()));
    @(negedge clk);
    rd32(8'h04, OKAY, 32'h5A5A5A5A);

    wr32(8'h10, 32'hDEADBEEF, 4'hF, SLVERR);
    rd32(8'h10, OKAY, 32'h0);
    rd32(8'h28, SLVERR, 32'h0);
    check("bm_out after err", 192'(bm_out),
          192'(128'h00000004_00000003_5A5A5A5A_11BB33DD));

    wr32(8'h24, 32'hFFFFFFFF, 4'hF, OKAY);
    rd32(8'h24, OKAY, 32'h1);
    check("irq idle", 192'(irq), 192'(0));
    bm_in = 128'h20;
    @(negedge clk);
    check("irq not yet", 192'(irq), 192'(0));
    @(negedge clk);
    check("irq rises", 192'(irq), 192'(1));
    rd32(8'h20, OKAY, 32'h1);
    // clear lands on the same edge as a new change
    bm_in = 128'h60;
    wr32(8'h20, 32'h1, 4'hF, OKAY);
    rd32(8'h20, OKAY, 32'h1);
    check("irq held", 192'(irq), 192'(1));
    rd32(8'h10, OKAY, 32'h60);
    wr32(8'h20, 32'h1, 4'hF, OKAY);
    rd32(8'h20, OKAY, 32'h0);
    check("irq cleared", 192'(irq), 192'(0));

    bready = 1'b0;
    bm_in = '0;
    awaddr = 8'h08; wdata = 32'h77; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp bvalid", 192'(bvalid), 192'(1));
    check("bp reg2", 192'(bm_out[95:64]), 192'(32'h77));
    @(negedge clk);
    check("bp bvalid held", 192'(bvalid), 192'(1));
    rst = 1'b1;
    #1;
    check("mid rst bvalid", 192'(bvalid), 192'(0));
    check("mid rst bm_out", 192'(bm_out), 192'({4{RV}}));
    check("mid rst awready", 192'(awready), 192'(0));
    check("mid rst irq", 192'(irq), 192'(0));
    @(negedge clk);
    rst = 1'b0;
    bready = 1'b1;
    #1;
    check("rel2 arready pre-edge", 192'(arready), 192'(0));
    @(negedge clk);
    check("rel2 awready", 192'(awready), 192'(1));
    check("rel2 wready", 192'(wready), 192'(1));
    check("rel2 arready", 192'(arready), 192'(1));
    check("rel2 bvalid", 192'(bvalid), 192'(0));

    bm_in6 = {64'h3333333333333333, 64'h2222222222222222,
              64'hFEDCBA9876543210};
    wr64(8'h08, 64'h0123456789ABCDEF, OKAY);
    rd64(8'h08, OKAY, 64'h0123456789ABCDEF);
    rd64(8'h10, OKAY, 64'hFEDCBA9876543210);
    rd64(8'h20, OKAY, 64'h3333333333333333);
    rd64(8'h28, OKAY, 64'h1);
    rd64(8'h38, SLVERR, 64'h0);
    check("bm_out64", 192'(bm_out6),
          192'({64'h0123456789ABCDEF, 64'h0}));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/bm_axil_regbank.md
# bm_axil_regbank

Parametrised AXI4-Lite slave register bank that connects the processing-system interconnect to a BondMachine core. It holds `N_OUT` writable registers that drive BondMachine inputs and `N_IN` read-only registers that sample BondMachine outputs. It also provides byte-strobe writes, SLVERR on unmapped or illegal accesses, and a change-detect interrupt. It sits between the AXI interconnect and the generated BondMachine top level, and replaces the fixed 4-register, 32-bit slave.

## Interface
- `DATA_WIDTH`, 32, AXI data width; 32 or 64 only.
- `ADDR_WIDTH`, 8, AXI address width; must cover `(N_OUT+N_IN+2)*DATA_WIDTH/8` bytes.
- `N_OUT`, 4, number of R/W output registers; 1..64.
- `N_IN`, 4, number of read-only input registers; 1..64.
- `RESET_VALUE`, 0, reset value of every output register.

Ports:
- `ACLK` in 1: single clock.
- `ARESET` in 1: asynchronous, active-high reset.
- `S_AXI_AWADDR` in ADDR_WIDTH / `S_AXI_AWPROT` in 3 (ignored) / `S_AXI_AWVALID` in 1 / `S_AXI_AWREADY` out 1: write-address channel.
- `S_AXI_WDATA` in DATA_WIDTH / `S_AXI_WSTRB` in DATA_WIDTH/8 / `S_AXI_WVALID` in 1 / `S_AXI_WREADY` out 1: write-data channel.
- `S_AXI_BRESP` out 2 / `S_AXI_BVALID` out 1 / `S_AXI_BREADY` in 1: write-response channel.
- `S_AXI_ARADDR` in ADDR_WIDTH / `S_AXI_ARPROT` in 3 (ignored) / `S_AXI_ARVALID` in 1 / `S_AXI_ARREADY` out 1: read-address channel.
- `S_AXI_RDATA` out DATA_WIDTH / `S_AXI_RRESP` out 2 / `S_AXI_RVALID` out 1 / `S_AXI_RREADY` in 1: read-data channel.
- `bm_out` out N_OUT*DATA_WIDTH: output registers, concatenated; register k is at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `bm_in` in N_IN*DATA_WIDTH: BondMachine outputs, same packing.
- `irq` out 1: level interrupt.

## Operation
- Word index = `ADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]`. Low address bits are ignored.
- Index map:
  - 0..N_OUT-1: output registers, R/W.
  - N_OUT..N_OUT+N_IN-1: input snapshot registers, RO.
  - N_OUT+N_IN: STATUS. Bit0 = CHANGED; write 1 clears, write 0 has no effect.
  - N_OUT+N_IN+1: IRQ_EN. Bit0 only; upper bits read 0.
  - Any higher index: unmapped.
- Writes:
  - Byte lane b is updated only when `WSTRB[b]`=1. Strobe 0 is accepted, returns OKAY and changes nothing.
  - Write to an RO or unmapped index: BRESP=SLVERR (2'b10), no state change.
- Reads:
  - Unmapped index: RRESP=SLVERR, RDATA=0.
  - All other reads: RRESP=OKAY.
- Input sampling:
  - Every cycle, `bm_in` is registered into the snapshot registers.
  - If the new sample differs from the held snapshot in any bit, CHANGED is set in the same edge.
  - `irq` = CHANGED & IRQ_EN, registered.
- Write FSM: IDLE, HAVE_AW, HAVE_W, RESP.
  - AW and W are accepted independently, in either order or together.
  - Each channel has a one-entry hold buffer.
  - The write commits on the edge where both buffers are full; the FSM then enters RESP.
  - RESP holds BVALID until BREADY, then returns to IDLE.
- Read FSM: IDLE, RESP.
  - AR is accepted only in IDLE.
  - RDATA/RRESP are registered from the current register contents.
  - RESP holds RVALID until RREADY.
- Write/read concurrency:
  - A read and a write to the same index committing in the same cycle: the read returns the old value.
  - A CHANGED clear and a new input change in the same cycle: set wins.

## Timing
- Reset values (ARESET high, asynchronous):
  - AWREADY/WREADY/ARREADY = 0; each becomes 1 on the first ACLK edge after ARESET falls.
  - BVALID = RVALID = 0, BRESP = RRESP = 0, RDATA = 0.
  - `bm_out` = RESET_VALUE per register.
  - Snapshots = 0, CHANGED = 0, IRQ_EN = 0, `irq` = 0.
- Channel readiness:
  - AWREADY = 1 iff the AW buffer is empty and the FSM is not in RESP. WREADY uses the same rule for the W buffer.
  - ARREADY = 1 iff the read FSM is in IDLE.
- Write latency:
  - AW and W handshaken in the same cycle T: `bm_out` updates at edge T+1 and BVALID rises at T+1.
  - Split handshakes: counted from the later of the two handshakes.
- Read latency: AR handshake at T gives RVALID at T+1.
- Back-to-back throughput: with BREADY/RREADY held high, one write per 2 cycles and one read per 2 cycles.
- `bm_in` change at edge T: snapshot and CHANGED update at T; `irq` rises at T+1 if enabled.
- Reset mid-transaction: all outstanding handshakes are dropped and no partial write is applied.

## Test plan
- Writes then reads:
  - Stimulus: DATA_WIDTH=32, N_OUT=4. Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read them back.
  - Required: each read returns its written value with OKAY; `bm_out` = 0x00000004_00000003_00000002_00000001.
- Strobes and split handshakes:
  - Stimulus: write 0xAABBCCDD with WSTRB=4'b0101 to 0x0 (reg0 = 0x11223344). Then a second write with W presented 3 cycles before AW.
  - Required: first write gives reg0 = 0x11BB33DD. Second write: BVALID exactly 1 cycle after the AW handshake.
- Errors:
  - Stimulus: write to index N_OUT (RO); read index N_OUT+N_IN+2.
  - Required: BRESP=SLVERR with the snapshot unchanged; RRESP=SLVERR with RDATA=0.
- Interrupt:
  - Stimulus: set IRQ_EN=1, then change `bm_in` bit 5. Next, write 1 to STATUS in the same cycle `bm_in` changes again.
  - Required: `irq`=1 one cycle after the change. On the simultaneous clear and change, CHANGED stays 1.
- Reset and backpressure:
  - Stimulus: assert ARESET while BVALID=1 and BREADY=0.
  - Required: BVALID drops immediately, `bm_out` = RESET_VALUE, readies return to 1 one edge after release.
- Parameter sweep:
  - Stimulus: DATA_WIDTH=64, N_OUT=2, N_IN=3; write 0x0123456789ABCDEF to 0x08, then read back.
  - Required: read returns the same value; a read of 0x10 returns `bm_in` word 0.
